// File: rtl/decoder38_scan_ctrl.sv
// decoder38_scan_ctrl: select-code sequencer for decoder38_vector.
// Steps the 3-bit code {in3,in2,in1} once every TICK_DIV clocks, up or down,
// wrapping mod 8. It runs either a single 8-code sweep or free-runs until stopped.
// Optional feature macro: SCAN_PAUSE_EN adds a 'pause' input that freezes the scan in RUN.
module decoder38_scan_ctrl #(
  parameter int unsigned TICK_DIV = 5,
  parameter int unsigned DIV_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       mode_sweep,
  input  logic       dir_up,
  input  logic       load_en,
  input  logic [2:0] load_code,
`ifdef SCAN_PAUSE_EN
  input  logic       pause,
`endif
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       step,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  state_t           r_state;
  logic [2:0]       r_code;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_steps;
  logic             r_sweep;
  logic             r_up;
  logic             r_step;
  logic             r_busy;
  logic             r_done;

  logic             w_tick;
  logic             w_pause;
  logic [2:0]       w_next_code;

`ifdef SCAN_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  // Divider terminal count and the next code in the latched direction (mod 8).
  always_comb begin
    w_tick      = (r_div == DIV_LAST);
    w_next_code = r_up ? (r_code + 3'd1) : (r_code - 3'd1);
  end

  // Scan FSM with registered code, step, busy and done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_code  <= 3'b111;
      r_div   <= '0;
      r_steps <= '0;
      r_sweep <= 1'b0;
      r_up    <= 1'b0;
      r_step  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_step <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_code  <= load_en ? load_code : 3'b111;
            r_div   <= '0;
            r_steps <= '0;
            r_sweep <= mode_sweep;
            r_up    <= dir_up;
            r_step  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // stop has priority over both pause and a same-cycle code step
          if (stop) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (!w_pause) begin
            if (w_tick) begin
              r_div <= '0;
              // seven steps taken means the eighth code has now been held in full
              if (r_sweep && (r_steps == 3'd7)) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_code  <= w_next_code;
                r_steps <= r_steps + 3'd1;
                r_step  <= 1'b1;
              end
            end else begin
              r_div <= r_div + DIV_W'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign {in3, in2, in1} = r_code;
  assign step            = r_step;
  assign busy            = r_busy;
  assign done            = r_done;

endmodule

// File: tb/tb_decoder38_scan_ctrl.sv
// Scoreboard bench for decoder38_scan_ctrl: two instances (TICK_DIV=5 and TICK_DIV=1)
// share stimulus. Each scan's expected step/done events (code and cycle) are derived
// arithmetically and queued; a monitor pops and compares whenever step or done fires.
module tb_decoder38_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       mode_sweep;
  logic       dir_up;
  logic       load_en;
  logic [2:0] load_code;
  logic       pause;

  logic in1_a, in2_a, in3_a, step_a, busy_a, done_a;
  logic in1_b, in2_b, in3_b, step_b, busy_b, done_b;
  logic [2:0] code_a, code_b;

  assign code_a = {in3_a, in2_a, in1_a};
  assign code_b = {in3_b, in2_b, in1_b};

  decoder38_scan_ctrl #(.TICK_DIV(5), .DIV_W(16)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .mode_sweep(mode_sweep), .dir_up(dir_up), .load_en(load_en), .load_code(load_code),
`ifdef SCAN_PAUSE_EN
    .pause(pause),
`endif
    .in1(in1_a), .in2(in2_a), .in3(in3_a), .step(step_a), .busy(busy_a), .done(done_a)
  );

  decoder38_scan_ctrl #(.TICK_DIV(1), .DIV_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .mode_sweep(mode_sweep), .dir_up(dir_up), .load_en(load_en), .load_code(load_code),
`ifdef SCAN_PAUSE_EN
    .pause(pause),
`endif
    .in1(in1_b), .in2(in2_b), .in3(in3_b), .step(step_b), .busy(busy_b), .done(done_b)
  );

  typedef struct {
    bit         is_done;
    logic [2:0] code;
    int         cyc;
  } evt_t;

  evt_t       q0[$];
  evt_t       q1[$];
  logic [2:0] last_code [2];
  int         cyc;
  int         n_total;
  int         n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void push_evt(input int idx, input evt_t e);
    if (idx == 0) q0.push_back(e);
    else          q1.push_back(e);
  endfunction

  function automatic int q_size(input int idx);
    return (idx == 0) ? q0.size() : q1.size();
  endfunction

  function automatic evt_t pop_evt(input int idx);
    if (idx == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Reference: the i-th code is c0 +/- i, shown from cycle s+1+i*T; a sweep ends with
  // done at s+1+8*T. Paused edges push later events back; nothing after stop/reset.
  task automatic plan(input int idx, input int T, input int s, input bit sweep, input bit up,
                      input logic [2:0] c0, input int stop_m, input int p_at, input int p_len);
    evt_t e;
    int   c;
    for (int i = 0; i < 1000; i++) begin
      c = s + 1 + i * T;
      if (c > p_at) c = c + p_len;
      if (stop_m >= 0 && c > stop_m) break;
      e.cyc = c;
      if (sweep && i == 8) begin
        e.is_done = 1'b1;
        e.code    = 3'b000;
        push_evt(idx, e);
        break;
      end
      e.is_done = 1'b0;
      e.code    = up ? (c0 + 3'(i)) : (c0 - 3'(i));
      push_evt(idx, e);
    end
  endtask

  task automatic mon(input int idx, input logic [2:0] code, input logic stp,
                     input logic dn, input logic bsy);
    evt_t e;
    if (!rst_n) begin
      last_code[idx] = 3'b111;
      return;
    end
    if (stp) begin
      if (q_size(idx) == 0) chk($sformatf("unexpected_step_u%0d", idx), 1, 0);
      else begin
        e = pop_evt(idx);
        chk($sformatf("step_kind_u%0d", idx), int'(e.is_done), 0);
        chk($sformatf("step_code_u%0d", idx), int'(code), int'(e.code));
        chk($sformatf("step_cycle_u%0d", idx), cyc, e.cyc);
      end
      chk($sformatf("busy_on_step_u%0d", idx), int'(bsy), 1);
    end else begin
      chk($sformatf("code_hold_u%0d", idx), int'(code), int'(last_code[idx]));
    end
    if (dn) begin
      if (q_size(idx) == 0) chk($sformatf("unexpected_done_u%0d", idx), 1, 0);
      else begin
        e = pop_evt(idx);
        chk($sformatf("done_kind_u%0d", idx), int'(e.is_done), 1);
        chk($sformatf("done_cycle_u%0d", idx), cyc, e.cyc);
      end
      chk($sformatf("busy_on_done_u%0d", idx), int'(bsy), 0);
    end
    last_code[idx] = code;
  endtask

  always @(posedge clk) begin
    #1;
    mon(0, code_a, step_a, done_a, busy_a);
    mon(1, code_b, step_b, done_b, busy_b);
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic run_scan(input bit sweep, input bit up, input bit ld, input logic [2:0] lc,
                          input int stop_after, input bit use_rst,
                          input int p_off, input int p_len, input bit noise);
    int         s;
    int         m;
    int         d;
    int         e_end;
    int         p_at;
    logic [2:0] c0;
    s    = cyc;
    c0   = ld ? lc : 3'b111;
    m    = (stop_after < 0) ? -1 : s + stop_after;
    p_at = (p_len > 0) ? s + p_off : 32'h3fff_ffff;
    plan(0, 5, s, sweep, up, c0, m, p_at, p_len);
    plan(1, 1, s, sweep, up, c0, m, p_at, p_len);
    start = 1'b1; mode_sweep = sweep; dir_up = up; load_en = ld; load_code = lc;
    tick;
    start = 1'b0;
    chk("busy_after_start_u0", int'(busy_a), 1);
    chk("busy_after_start_u1", int'(busy_b), 1);
    d     = s + 1 + 8 * 5 + p_len;
    e_end = (m >= 0 && (!sweep || m < d)) ? m : d;
    while (cyc <= e_end) begin
      stop  = (cyc == m) && !use_rst;
      rst_n = !((cyc == m) && use_rst);
      pause = (cyc >= p_at) && (cyc < p_at + p_len);
      if (noise) begin
        mode_sweep = 1'($urandom);
        dir_up     = 1'($urandom);
        load_en    = 1'($urandom);
        load_code  = 3'($urandom);
        start      = (cyc <= s + 8) && ($urandom % 4 == 0);
      end
      tick;
    end
    start = 1'b0; stop = 1'b0; pause = 1'b0;
    if (use_rst) begin
      chk("rst_code_u0", int'(code_a), 7);
      chk("rst_code_u1", int'(code_b), 7);
      chk("rst_step_u0", int'(step_a), 0);
      chk("rst_busy_u0", int'(busy_a), 0);
      chk("rst_done_u0", int'(done_a), 0);
      chk("rst_busy_u1", int'(busy_b), 0);
      rst_n = 1'b1;
    end else begin
      chk("busy_at_end_u0", int'(busy_a), 0);
      chk("busy_at_end_u1", int'(busy_b), 0);
    end
    repeat ($urandom % 3) tick;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit sw;
    bit up;
    bit ld;
    bit ur;
    int sa;
    int po;
    int pl;
    n_total = 0; n_pass = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode_sweep = 1'b0; dir_up = 1'b0;
    load_en = 1'b0; load_code = 3'b000; pause = 1'b0;
    last_code[0] = 3'b111; last_code[1] = 3'b111;
    repeat (3) tick;
    chk("reset_code_u0", int'(code_a), 7);
    chk("reset_step_u0", int'(step_a), 0);
    chk("reset_busy_u0", int'(busy_a), 0);
    chk("reset_done_u0", int'(done_a), 0);
    chk("reset_code_u1", int'(code_b), 7);
    rst_n = 1'b1;
    tick;

    // Down-sweep from 7: 7..0 held TICK_DIV each, done 8*TICK_DIV after first step.
    run_scan(1'b1, 1'b0, 1'b0, 3'd0, -1, 1'b0, 0, 0, 1'b0);
    chk("sweep_final_code_u0", int'(code_a), 0);
    chk("sweep_final_code_u1", int'(code_b), 0);

    // Free-run up from 6 with wrap, stopped after 20 clk.
    run_scan(1'b0, 1'b1, 1'b1, 3'd6, 20, 1'b0, 0, 0, 1'b0);

    // Reset in the middle of a run.
    run_scan(1'b0, 1'b1, 1'b0, 3'd0, 13, 1'b1, 0, 0, 1'b0);

    // start together with stop in IDLE is ignored.
    start = 1'b1; stop = 1'b1;
    tick;
    start = 1'b0; stop = 1'b0;
    tick;
    chk("start_stop_idle_u0", int'(busy_a), 0);
    chk("start_stop_idle_u1", int'(busy_b), 0);

`ifdef SCAN_PAUSE_EN
    // Pause for 10 clk mid-hold delays the sweep by 10; stop during pause goes idle.
    run_scan(1'b1, 1'b0, 1'b0, 3'd0, -1, 1'b0, 12, 10, 1'b0);
    run_scan(1'b1, 1'b1, 1'b1, 3'd2, 16, 1'b0, 12, 10, 1'b0);
`endif

    for (int k = 0; k < 24; k++) begin
      sw = 1'($urandom); up = 1'($urandom); ld = 1'($urandom);
      sa = -1; ur = 1'b0; po = 0; pl = 0;
      if (!sw) sa = 1 + int'($urandom % 40);
      else if ($urandom % 4 == 0) sa = 1 + int'($urandom % 45);
      if (sa > 0 && ($urandom % 6 == 0)) ur = 1'b1;
`ifdef SCAN_PAUSE_EN
      if ($urandom % 3 == 0) begin
        po = 1 + int'($urandom % 20);
        pl = 1 + int'($urandom % 12);
      end
`endif
      run_scan(sw, up, ld, 3'($urandom), sa, ur, po, pl, 1'b1);
    end

    repeat (5) tick;
    chk("queue_drained_u0", q0.size(), 0);
    chk("queue_drained_u1", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
